uart_buffered: RTL

//  Full-duplex UART with parametrised word width and TX/RX FIFOs, replacing the unbuffered

---
 rtl/uart_buffered_if.sv | 30 +++
 rtl/uart_buffered.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_if.sv
// Host-side streams of uart_buffered.
// TX push stream, RX pop stream and FIFO status.
interface uart_buffered_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic [LW-1:0]        tx_level_o;
  logic                 tx_idle_o;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic [LW-1:0]        rx_level_o;

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, tx_level_o, tx_idle_o,
    input  rx_data_o, rx_valid_o, rx_level_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, tx_level_o, tx_idle_o,
    output rx_data_o, rx_valid_o, rx_level_o
  );
endinterface

// File: rtl/uart_buffered.sv
// Full-duplex UART with TX/RX FIFOs and sticky
// parity, framing and overrun flags.
module uart_buffered_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = LW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the full-FIFO push lands in
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module uart_buffered #(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int DATA_BITS           = 8,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           serial_i,
  output logic                           serial_o,
  output logic                           parity_error_o,
  output logic                           framing_error_o,
  output logic                           overrun_o,
  input  logic                           error_clear_i,
  uart_buffered_if.slave                 bus
);
  localparam int CDW = CLOCK_DIVIDER_WIDTH;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

  typedef logic [CDW-1:0]       div_t;
  typedef logic [DATA_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  word_t tx_head;
  logic  tx_full, tx_empty, tx_pop, tx_load;

  uart_buffered_fifo #(
    .W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)
  ) u_tx_fifo (
    .clk(clock_i), .rst(reset_i),
    .push(bus.tx_valid_i & ~tx_full), .pop(tx_pop),
    .din(bus.tx_data_i), .dout(tx_head),
    .level(bus.tx_level_o), .full(tx_full), .empty(tx_empty)
  );

  tx_state_t  tx_state, tx_state_n;
  div_t       tx_div, tx_div_n, tx_cnt, tx_cnt_n;
  logic [3:0] tx_bit, tx_bit_n;
  word_t      tx_sh, tx_sh_n;
  logic       tx_pbit, tx_pbit_n, tx_two, tx_two_n;
  logic       tx_pen, tx_pen_n, tx_stop2, tx_stop2_n;
  logic       tx_line, tx_line_n, tx_end;

  assign tx_end         = tx_cnt == tx_div - 1'b1;
  assign serial_o       = tx_line;
  assign bus.tx_ready_o = ~tx_full;
  assign bus.tx_idle_o  = tx_empty & (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_div_n   = tx_div;
    tx_cnt_n   = tx_end ? '0 : tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pbit_n  = tx_pbit;
    tx_two_n   = tx_two;
    tx_pen_n   = tx_pen;
    tx_stop2_n = tx_stop2;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
        tx_load   = ~tx_empty;
      end
      TX_START: if (tx_end) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
        tx_line_n  = tx_sh[0];
      end
      TX_DATA: if (tx_end) begin
        if (tx_bit == LAST) begin
          tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
          tx_line_n  = tx_pen ? tx_pbit : 1'b1;
          tx_stop2_n = 1'b0;
        end else begin
          tx_bit_n  = tx_bit + 1'b1;
          tx_sh_n   = tx_sh >> 1;
          tx_line_n = tx_sh[1];
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_state_n = TX_STOP;
        tx_line_n  = 1'b1;
        tx_stop2_n = 1'b0;
      end
      TX_STOP: if (tx_end) begin
        if (tx_two & ~tx_stop2) begin
          tx_stop2_n = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
          tx_load    = ~tx_empty;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // chaining the next word here keeps frames gap-free
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_n = TX_START;
      tx_cnt_n   = '0;
      tx_line_n  = 1'b0;
      tx_sh_n    = tx_head;
      tx_div_n   = clock_divider_i;
      tx_two_n   = two_stop_bits_i;
      tx_pen_n   = parity_bit_i;
      tx_pbit_n  = parity_even_i ? ^tx_head : ~^tx_head;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state <= TX_IDLE;
      tx_div   <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_pbit  <= 1'b0;
      tx_two   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_div   <= tx_div_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_pbit  <= tx_pbit_n;
      tx_two   <= tx_two_n;
      tx_pen   <= tx_pen_n;
      tx_stop2 <= tx_stop2_n;
      tx_line  <= tx_line_n;
    end
  end

  logic [1:0] sync;
  logic       rx_s, rx_prev;
  rx_state_t  rx_state, rx_state_n;
  div_t       rx_div, rx_div_n, rx_cnt, rx_cnt_n;
  logic [3:0] rx_bit, rx_bit_n;
  word_t      rx_sh, rx_sh_n;
  logic       rx_pbit, rx_pbit_n, rx_pen, rx_pen_n;
  logic       rx_even, rx_even_n, rx_end, rx_mid;
  logic       rx_push, rx_perr, rx_ferr, rx_full, rx_empty, rx_pop;

  assign rx_s           = sync[1];
  assign rx_end         = rx_cnt == rx_div - 1'b1;
  assign rx_mid         = rx_cnt == (rx_div >> 1) - 1'b1;
  assign rx_pop         = bus.rx_ready_i & ~rx_empty;
  assign bus.rx_valid_o = ~rx_empty;

  uart_buffered_fifo #(
    .W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)
  ) u_rx_fifo (
    .clk(clock_i), .rst(reset_i),
    .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(bus.rx_data_o),
    .level(bus.rx_level_o), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    rx_state_n = rx_state;
    rx_div_n   = rx_div;
    rx_cnt_n   = rx_end ? '0 : rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    rx_pen_n   = rx_pen;
    rx_even_n  = rx_even;
    rx_push    = 1'b0;
    rx_perr    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev & ~rx_s) begin
          rx_state_n = RX_START;
          rx_div_n   = clock_divider_i;
          rx_pen_n   = parity_bit_i;
          rx_even_n  = parity_even_i;
        end
      end
      RX_START: if (rx_mid) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == LAST)
          rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
        else
          rx_bit_n = rx_bit + 1'b1;
      end
      RX_PARITY: if (rx_end) begin
        rx_pbit_n  = rx_s;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        rx_push    = 1'b1;
        rx_perr    = rx_pen & (^{rx_sh, rx_pbit} ^ ~rx_even);
        rx_ferr    = ~rx_s;
        rx_state_n = rx_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= '0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
      rx_pen   <= 1'b0;
      rx_even  <= 1'b0;
    end else begin
      sync     <= {sync[0], serial_i};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_div   <= rx_div_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_pbit  <= rx_pbit_n;
      rx_pen   <= rx_pen_n;
      rx_even  <= rx_even_n;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      if (rx_perr)            parity_error_o <= 1'b1;
      else if (error_clear_i) parity_error_o <= 1'b0;
      if (rx_ferr)            framing_error_o <= 1'b1;
      else if (error_clear_i) framing_error_o <= 1'b0;
      if (rx_push & rx_full & ~rx_pop) overrun_o <= 1'b1;
      else if (error_clear_i)          overrun_o <= 1'b0;
    end
  end
endmodule
